// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants, ID values and state encoding for the SRAM-like to AXI bridge.
package sram_axi_bridge_pkg;

  // AXI attribute encodings driven on AR/AW
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [3:0] CACHE_WB   = 4'b1111;
  localparam logic [3:0] CACHE_UC   = 4'b0000;

  // Default transaction IDs per request source
  localparam int INST_ID_DEF = 0;
  localparam int DATA_ID_DEF = 1;

  // Bridge FSM encoding (exported through the fsm_state debug port)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_AWW = 3'd3,
    WR_B   = 3'd4
  } state_t;

  // Map the core's cacheable attribute onto AXI AxCACHE
  function automatic logic [3:0] axi_cache(input logic cacheable);
    return cacheable ? CACHE_WB : CACHE_UC;
  endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Converts the core's split inst/data SRAM-like ports into one AXI master
// with a single outstanding single-beat transaction. Data has priority.
//
// Handshake rules: an AXI transfer happens on a rising edge where both
// valid and ready are high. This block raises a valid only from a register,
// keeps it and its payload stable until the matching ready is seen, and never
// makes a valid depend on the corresponding ready. On the core side, a
// request is taken in the cycle where req and addr_ok are both high, and
// data_ok is a one-cycle pulse carrying read data or write completion.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int ID_W    = 4,
  parameter int INST_ID = INST_ID_DEF,
  parameter int DATA_ID = DATA_ID_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  // instruction side
  input  logic            inst_req,
  input  logic            inst_cache,
  input  logic [31:0]     inst_addr,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [31:0]     inst_rdata,
  // data side
  input  logic            data_req,
  input  logic            data_cache,
  input  logic            data_wr,
  input  logic [3:0]      data_wstrb,
  input  logic [31:0]     data_addr,
  input  logic [2:0]      data_size,
  input  logic [31:0]     data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [31:0]     data_rdata,
  // AXI read address
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [3:0]      arcache,
  output logic            arvalid,
  input  logic            arready,
  // AXI read data
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AXI write address
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [3:0]      awcache,
  output logic            awvalid,
  input  logic            awready,
  // AXI write data
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI write response
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  // debug
  output state_t          fsm_state
);

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        req_cache;
  logic        req_is_data;

  // Only one beat is ever outstanding, so ID/response/last carry no information.
  logic unused_axi_inputs;
  assign unused_axi_inputs = ^{rid, rresp, rlast, bid, bresp};

  // Acceptance is only possible in IDLE; data beats inst in the same cycle.
  assign data_addr_ok = resetn && (state == IDLE) && data_req;
  assign inst_addr_ok = resetn && (state == IDLE) && inst_req && !data_req;

  // Channel payloads come straight from the latched request.
  assign arid    = req_is_data ? ID_W'(DATA_ID) : ID_W'(INST_ID);
  assign araddr  = req_addr;
  assign arlen   = 8'd0;
  assign arsize  = req_size;
  assign arburst = BURST_INCR;
  assign arcache = axi_cache(req_cache);

  assign awid    = ID_W'(DATA_ID);
  assign awaddr  = req_addr;
  assign awlen   = 8'd0;
  assign awsize  = req_size;
  assign awburst = BURST_INCR;
  assign awcache = axi_cache(req_cache);

  assign wdata   = req_wdata;
  assign wstrb   = req_wstrb;
  assign wlast   = 1'b1;

  assign fsm_state = state;

  // Bridge FSM: latches the request, runs the AXI channels, pulses data_ok.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      req_addr     <= 32'd0;
      req_wdata    <= 32'd0;
      req_size     <= 3'd0;
      req_wstrb    <= 4'd0;
      req_cache    <= 1'b0;
      req_is_data  <= 1'b0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'd0;
      data_rdata   <= 32'd0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            req_addr    <= data_addr;
            req_wdata   <= data_wdata;
            req_size    <= data_size;
            req_wstrb   <= data_wstrb;
            req_cache   <= data_cache;
            req_is_data <= 1'b1;
            if (data_wr) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_AWW;
            end else begin
              arvalid <= 1'b1;
              state   <= RD_AR;
            end
          end else if (inst_req) begin
            req_addr    <= inst_addr;
            req_wdata   <= 32'd0;
            req_size    <= SIZE_WORD;
            req_wstrb   <= 4'd0;
            req_cache   <= inst_cache;
            req_is_data <= 1'b0;
            arvalid     <= 1'b1;
            state       <= RD_AR;
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (req_is_data) begin
              data_rdata   <= rdata;
              data_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= rdata;
              inst_data_ok <= 1'b1;
            end
            state <= IDLE;
          end
        end
        WR_AWW: begin
          // AW and W complete independently; leave once neither is pending.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            bready       <= 1'b0;
            data_data_ok <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed core requests, a latency-programmable
// AXI slave, and a response scoreboard fed at acceptance time.
module tb_sram_axi_bridge;
  import sram_axi_bridge_pkg::*;

  localparam int ID_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            inst_req = 1'b0, inst_cache = 1'b0;
  logic [31:0]     inst_addr = 32'd0;
  logic            inst_addr_ok, inst_data_ok;
  logic [31:0]     inst_rdata;
  logic            data_req = 1'b0, data_cache = 1'b0, data_wr = 1'b0;
  logic [3:0]      data_wstrb = 4'd0;
  logic [31:0]     data_addr = 32'd0, data_wdata = 32'd0;
  logic [2:0]      data_size = 3'd0;
  logic            data_addr_ok, data_data_ok;
  logic [31:0]     data_rdata;
  logic [ID_W-1:0] arid, awid;
  logic [31:0]     araddr, awaddr, wdata;
  logic [7:0]      arlen, awlen;
  logic [2:0]      arsize, awsize;
  logic [1:0]      arburst, awburst;
  logic [3:0]      arcache, awcache, wstrb;
  logic            arvalid, awvalid, wvalid, wlast, rready, bready;
  logic            arready = 1'b0, awready = 1'b0, wready = 1'b0;
  logic [ID_W-1:0] rid = '0, bid = '0;
  logic [31:0]     rdata = 32'd0;
  logic [1:0]      rresp = 2'd0, bresp = 2'd0;
  logic            rlast = 1'b1, rvalid = 1'b0, bvalid = 1'b0;
  state_t          fsm_state;

  sram_axi_bridge #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_cache(data_cache), .data_wr(data_wr),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_size(data_size),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awcache(awcache), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [42:0] exp_ar_q[$];   // {id, size, cache, addr}
  logic [42:0] exp_aw_q[$];   // {id, size, cache, addr}
  logic [35:0] exp_w_q[$];    // {wstrb, wdata}
  logic [33:0] exp_rsp_q[$];  // {is_data, check_data, data}
  logic [31:0] slv_rdata_q[$];
  int outstanding = 0;

  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;

  logic [42:0] ar_now, aw_now;
  logic [35:0] w_now;
  assign ar_now = {arid, arsize, arcache, araddr};
  assign aw_now = {awid, awsize, awcache, awaddr};
  assign w_now  = {wstrb, wdata};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave + response monitor ----------------
  bit hs_ar, hs_r, hs_aw, hs_w, hs_b;
  bit r_pend = 0, aw_done = 0, w_done = 0, b_pend = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [ID_W-1:0] r_id = '0;
  logic arvalid_p = 0, arready_p = 0, awvalid_p = 0, awready_p = 0;
  logic wvalid_p = 0, wready_p = 0, rready_p = 0, bready_p = 0;
  logic [42:0] ar_snap = '0, aw_snap = '0;
  logic [35:0] w_snap = '0;

  always @(negedge clk) begin
    logic [42:0] e_ar;
    logic [33:0] e_rsp;
    logic [1:0]  exp_ok;
    if (!resetn) begin
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      r_pend = 0; aw_done = 0; w_done = 0; b_pend = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      arvalid_p = 0; arready_p = 0; awvalid_p = 0; awready_p = 0;
      wvalid_p = 0; wready_p = 0; rready_p = 0; bready_p = 0;
    end else begin
      // handshakes completed on the rising edge just passed
      hs_ar = arready;
      hs_aw = awready;
      hs_w  = wready;
      hs_r  = rvalid && rready_p;
      hs_b  = bvalid && bready_p;

      // a stalled valid must keep itself and its payload
      if (arvalid_p && !arready_p) check("ar_hold", {arvalid, ar_now}, {1'b1, ar_snap});
      if (awvalid_p && !awready_p) check("aw_hold", {awvalid, aw_now}, {1'b1, aw_snap});
      if (wvalid_p && !wready_p)   check("w_hold", {wvalid, w_now}, {1'b1, w_snap});

      // data_ok must appear exactly in the cycle after an R or B handshake
      exp_ok = 2'b00;
      if (hs_r) exp_ok = (r_id == 4'd1) ? 2'b01 : 2'b10;
      if (hs_b) exp_ok = 2'b01;
      if (hs_r || hs_b || inst_data_ok || data_data_ok)
        check("data_ok_timing", {inst_data_ok, data_data_ok}, exp_ok);

      // response scoreboard
      if (inst_data_ok || data_data_ok) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e_rsp = exp_rsp_q.pop_front();
          if (e_rsp[32])
            check("rsp_data", {data_data_ok, (data_data_ok ? data_rdata : inst_rdata)},
                  {e_rsp[33], e_rsp[31:0]});
          else
            check("rsp_src", data_data_ok, e_rsp[33]);
        end
        outstanding--;
      end

      // AR channel
      if (hs_ar) begin
        arready = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
        check("arvalid_drop", arvalid, 0);
      end else if (arvalid && !arready) begin
        if (ar_cnt >= ar_delay) begin
          if (exp_ar_q.size() == 0) begin
            check("ar_unexpected", 1, 0);
          end else begin
            e_ar = exp_ar_q.pop_front();
            check("ar_fields", ar_now, e_ar);
            r_id = e_ar[42:39];
          end
          check("ar_len_burst", {arlen, arburst}, {8'd0, 2'b01});
          arready = 1;
        end else begin
          ar_cnt++;
        end
      end

      // R channel
      if (hs_r) begin
        rvalid = 0; r_pend = 0;
      end else if (r_pend && !rvalid) begin
        if (r_cnt >= r_delay) begin
          rvalid = 1;
          rid    = r_id;
          rdata  = (slv_rdata_q.size() != 0) ? slv_rdata_q.pop_front() : 32'hBAD0BAD0;
        end else begin
          r_cnt++;
        end
      end

      // AW channel
      if (hs_aw) begin
        awready = 0; aw_done = 1; aw_cnt = 0;
        check("awvalid_drop", awvalid, 0);
      end else if (awvalid && !awready && !aw_done) begin
        if (aw_cnt >= aw_delay) begin
          if (exp_aw_q.size() == 0) check("aw_unexpected", 1, 0);
          else check("aw_fields", aw_now, exp_aw_q.pop_front());
          check("aw_len_burst", {awlen, awburst}, {8'd0, 2'b01});
          awready = 1;
        end else begin
          aw_cnt++;
        end
      end

      // W channel
      if (hs_w) begin
        wready = 0; w_done = 1; w_cnt = 0;
        check("wvalid_drop", wvalid, 0);
      end else if (wvalid && !wready && !w_done) begin
        if (w_cnt >= w_delay) begin
          if (exp_w_q.size() == 0) check("w_unexpected", 1, 0);
          else check("w_fields", {wlast, w_now}, {1'b1, exp_w_q.pop_front()});
          wready = 1;
        end else begin
          w_cnt++;
        end
      end

      // B may only be accepted after both AW and W are done
      if (awvalid || wvalid) check("bready_early", bready, 0);
      if (hs_b) begin
        bvalid = 0; b_pend = 0;
      end else if (aw_done && w_done) begin
        aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
      end
      if (b_pend && !bvalid && !hs_b) begin
        if (b_cnt >= b_delay) begin
          bvalid = 1;
          bid    = 4'd1;
        end else begin
          b_cnt++;
        end
      end

      // values seen at the upcoming rising edge
      arvalid_p = arvalid; arready_p = arready; ar_snap = ar_now;
      awvalid_p = awvalid; awready_p = awready; aw_snap = aw_now;
      wvalid_p  = wvalid;  wready_p  = wready;  w_snap  = w_now;
      rready_p  = rready;  bready_p  = bready;
    end
  end

  // No request may be accepted while a transaction is in flight
  always @(negedge clk) begin
    #2;
    if (resetn && outstanding > 0 && !(inst_data_ok || data_data_ok) && (inst_req || data_req))
      check("addr_ok_busy", {inst_addr_ok, data_addr_ok}, 2'b00);
  end

  // ---------------- driver tasks ----------------
  task automatic issue_inst(input logic [31:0] addr, input logic cache,
                            input logic [31:0] rd, input bit b2b);
    int n;
    @(negedge clk);
    inst_req = 1; inst_addr = addr; inst_cache = cache;
    #1;
    n = 0;
    while (!inst_addr_ok && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!inst_addr_ok) begin
      check("inst_accept_timeout", 0, 1);
      inst_req = 0;
      return;
    end
    if (b2b) check("inst_accept_on_data_ok", inst_data_ok | data_data_ok, 1);
    exp_ar_q.push_back({4'd0, 3'd2, (cache ? 4'hF : 4'h0), addr});
    slv_rdata_q.push_back(rd);
    exp_rsp_q.push_back({1'b0, 1'b1, rd});
    @(posedge clk); #1;
    outstanding++;
    inst_req = 0;
  endtask

  task automatic issue_data(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                            input logic [3:0] strb, input logic [31:0] wd, input logic cache,
                            input logic [31:0] rd);
    int n;
    @(negedge clk);
    data_req = 1; data_wr = wr; data_size = size; data_addr = addr;
    data_wstrb = strb; data_wdata = wd; data_cache = cache;
    #1;
    n = 0;
    while (!data_addr_ok && n < 300) begin
      @(negedge clk); #1; n++;
    end
    if (!data_addr_ok) begin
      check("data_accept_timeout", 0, 1);
      data_req = 0;
      return;
    end
    if (inst_req) check("inst_loses_arb", inst_addr_ok, 0);
    if (wr) begin
      exp_aw_q.push_back({4'd1, size, (cache ? 4'hF : 4'h0), addr});
      exp_w_q.push_back({strb, wd});
      exp_rsp_q.push_back({1'b1, 1'b0, 32'd0});
    end else begin
      exp_ar_q.push_back({4'd1, size, (cache ? 4'hF : 4'h0), addr});
      slv_rdata_q.push_back(rd);
      exp_rsp_q.push_back({1'b1, 1'b1, rd});
    end
    @(posedge clk); #1;
    outstanding++;
    data_req = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    if (exp_rsp_q.size() != 0) check("rsp_timeout", exp_rsp_q.size(), 0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] b2b_data [8] = '{32'h3C080001, 32'h25080004, 32'hAD090000, 32'h8D0A0004,
                                32'h1000FFFF, 32'h00000000, 32'hFFFFFFFF, 32'h03E00008};

  initial begin
    int n;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst0_ctrl", {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, 0);
    check("rst0_rdata", {inst_rdata, data_rdata}, 0);
    check("rst0_state", fsm_state, IDLE);
    @(negedge clk);
    resetn = 1;

    // plain fetch, immediate AR, R after two cycles
    ar_delay = 0; r_delay = 2;
    issue_inst(32'hBFC00000, 1'b0, 32'h3C1D0001, 1'b0);
    wait_done();

    // simultaneous data read and fetch: data wins, fetch taken on data_ok cycle
    r_delay = 1;
    fork
      issue_data(1'b0, 3'd0, 32'h80001003, 4'h0, 32'h0, 1'b0, 32'h11223344);
      issue_inst(32'hBFC00004, 1'b1, 32'h24080005, 1'b1);
    join
    wait_done();

    // write with W accepted three cycles ahead of AW
    aw_delay = 3; w_delay = 0; b_delay = 2;
    issue_data(1'b1, 3'd1, 32'h80002000, 4'b0011, 32'hDEADBEEF, 1'b1, 32'h0);
    wait_done();

    // write with AW first, W late
    aw_delay = 0; w_delay = 2; b_delay = 0;
    issue_data(1'b1, 3'd0, 32'h80002003, 4'b1000, 32'h5A000000, 1'b0, 32'h0);
    wait_done();

    // AR stalled five cycles while a fetch waits behind it
    ar_delay = 5; r_delay = 0; aw_delay = 0; w_delay = 0;
    fork
      issue_data(1'b0, 3'd2, 32'h80003008, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D);
      begin
        repeat (2) @(negedge clk);
        issue_inst(32'hBFC00008, 1'b0, 32'h00000000, 1'b1);
      end
    join
    wait_done();

    // reset while waiting in RD_R
    ar_delay = 0; r_delay = 40;
    issue_inst(32'hBFC0000C, 1'b1, 32'h12345678, 1'b0);
    n = 0;
    while (!rready && n < 50) begin
      @(negedge clk); n++;
    end
    check("pre_rst_state", fsm_state, RD_R);
    @(negedge clk);
    resetn = 0;
    @(posedge clk); #1;
    check("rst1_ctrl", {arvalid, rready, awvalid, wvalid, bready,
                        inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    check("rst1_rdata", {inst_rdata, data_rdata}, 0);
    check("rst1_state", fsm_state, IDLE);
    @(negedge clk);
    exp_rsp_q.delete(); slv_rdata_q.delete();
    exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
    outstanding = 0;
    @(negedge clk);
    resetn = 1;
    r_delay = 1;
    issue_inst(32'hBFC00010, 1'b0, 32'h8FA40010, 1'b0);
    wait_done();

    // eight back-to-back fetches against a zero-latency slave
    ar_delay = 0; r_delay = 0;
    for (int i = 0; i < 8; i++)
      issue_inst(32'h1FC00000 + 32'(i * 4), 1'b0, b2b_data[i], i > 0);
    wait_done();

    check("ar_q_empty", exp_ar_q.size(), 0);
    check("aw_q_empty", exp_aw_q.size() + exp_w_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #400000;
    check("watchdog", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's split SRAM-like interfaces (inst_* and data_*) and converts them to a single AXI master port toward the memory system / SoC crossbar.
- Arbitrates instruction and data requests and keeps exactly one transaction outstanding.
- Returns read data and write completion to the core as one-cycle data_ok pulses.

Parameters:
- ID_W, 4, width of AXI ID fields
- INST_ID, 0, ARID used for instruction fetches
- DATA_ID, 1, ARID/AWID used for data accesses

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_req/inst_cache  in  1/1  fetch request; cacheable attribute
- inst_addr  in  32  fetch physical address (word read)
- inst_addr_ok/inst_data_ok  out  1/1  request accepted; read data valid (pulse)
- inst_rdata  out  32  fetched word
- data_req/data_cache/data_wr  in  1/1/1  data request; cacheable; 1=write
- data_wstrb  in  4  byte enables for writes
- data_addr  in  32  data physical address
- data_size  in  3  0=byte, 1=half, 2=word
- data_wdata  in  32  store data
- data_addr_ok/data_data_ok  out  1/1  accepted; read data valid or write done (pulse)
- data_rdata  out  32  load data
- arid/araddr/arlen/arsize/arburst/arcache/arvalid  out  ID_W/32/8/3/2/4/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  AXI read data
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awcache/awvalid  out  ID_W/32/8/3/2/4/1  AXI write address
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1  AXI write data
- wready  in  1
- bid/bresp/bvalid  in  ID_W/2/1  AXI write response
- bready  out  1

Behaviour:
- FSM states: IDLE, RD_AR, RD_R, WR_AWW, WR_B.
- Reset (sync, resetn=0): state IDLE; all valid/ready outputs, addr_ok and data_ok are 0; rdata outputs 0; internal request registers cleared. Reset mid-transaction abandons it; the AXI slave is reset with the same signal.
- Acceptance happens only in IDLE. addr_ok is combinational from the req lines.
  - Data wins over inst: data_addr_ok = data_req; inst_addr_ok = inst_req && !data_req.
  - On acceptance, latch addr, size, wstrb, wdata, cache and source.
  - Next state: RD_AR for a read, WR_AWW for a write.
- RD_AR: arvalid=1 with latched fields; arlen=0, arburst=2'b01, arsize = data_size (inst: 2), arid = source ID, arcache = cache ? 4'b1111 : 4'b0000. On arready go to RD_R.
- RD_R: rready=1. On rvalid:
  - register rdata into the source's rdata output;
  - pulse that source's data_ok for exactly the next cycle;
  - return to IDLE.
  - rresp, rid and rlast are ignored (single outstanding, len 0).
- WR_AWW:
  - awvalid and wvalid are asserted together; each drops independently after its own handshake (awvalid&&awready, wvalid&&wready). Handshakes may land in the same cycle or either order.
  - wlast=1, awlen=0, awburst=2'b01, awsize=data_size, wstrb=latched data_wstrb; address is not realigned.
  - Go to WR_B when both handshakes are complete.
- WR_B: bready=1. On bvalid, pulse data_data_ok the next cycle and return to IDLE. bresp is ignored.
- Outputs stay stable while valid is high and ready is low (AXI rule).
- Back-to-back: the data_ok cycle coincides with IDLE, so a new request may be accepted in that same cycle. Minimum latency:
  - read: accept cycle, then 1 cycle to AR handshake, then R; data_ok 1 cycle after the R handshake;
  - write: data_ok 1 cycle after the B handshake.
- Any req arriving while not in IDLE sees addr_ok=0 and must be held by the core.
- Inst is never starved beyond one data transaction per arbitration when data_req is low.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR=2'b01, SIZE_WORD=3'd2, CACHE_WB=4'b1111, CACHE_UC=4'b0000;
  - the ID values;
  - FSM state encoding.
- Single flat module; no sub-module is natural.

Test Plan:
- inst_req addr 0xBFC00000, slave arready immediate, rdata 0x3C1D0001 after 2 cycles -> arid=0, arsize=2, arcache=0 with inst_cache=0; inst_data_ok one-cycle pulse with inst_rdata=0x3C1D0001.
- inst_req and data_req (read, size 0, addr 0x80001003) in the same cycle -> data_addr_ok=1, inst_addr_ok=0; araddr=0x80001003, arsize=0, arid=1; inst accepted on the cycle data_data_ok pulses.
- Write addr 0x80002000, wstrb 4'b0011, wdata 0xDEADBEEF; wready 3 cycles before awready -> wvalid drops after its handshake, awvalid holds; bready only after both; data_data_ok pulses 1 cycle after bvalid.
- arready held low 5 cycles -> araddr/arid/arsize stable and arvalid high throughout; no addr_ok while busy.
- resetn=0 asserted in RD_R -> next cycle all valid/ready/ok outputs 0, state IDLE; fresh request accepted after reset released.
- 8 back-to-back inst reads with zero-latency slave -> each accepted on its predecessor's data_ok cycle; data returned in order with correct values.
